ttlc_io_arb: RTL
================

Name: ttlc_io_arb

Overview:
- Arbitrates the bit-addressed TTLC I/O bus (8-bit bit address, write enable, 1-bit write data, 1-bit read data) between two requesters: the MC14500 core and a byte-wide host port (LISA CPU/debug).
- The core has absolute priority and is never stalled.
- Each host word access is split into WORD_BITS single-bit accesses, issued in cycles the core leaves idle.
- Sits between the core/host and the I/O register block. A starvation counter can request a core hold.

Parameters:
WORD_BITS, 8, host word width; bit i maps to bit address (base + i) mod 256
STARVE_LIMIT, 16, consecutive core-blocked XFER cycles before core_hold asserts; 0 disables core_hold

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
core_req  input  1  core drives the bus this cycle
core_addr  input  8  core bit address
core_we  input  1  core write enable
core_wdata  input  1  core write data
core_rdata  output  1  read data to core (combinational from io_rdata)
core_hold  output  1  registered; asks the core sequencer to stop issuing core_req
host_req  input  1  start host word access (sampled only in IDLE)
host_we  input  1  1 = write, 0 = read
host_addr  input  8  base bit address
host_wdata  input  WORD_BITS  write word, LSB to base
host_ack  output  1  one-cycle completion pulse
host_rdata  output  WORD_BITS  read word, valid while host_ack = 1, held until next read completes
host_busy  output  1  state != IDLE
io_addr  output  8  bit address to I/O block
io_we  output  1  write strobe to I/O block
io_wdata  output  1  write data to I/O block
io_rdata  input  1  combinational read data from I/O block

Behaviour:
- Reset (rst_n low, asynchronous) sets:
  - state to IDLE
  - bit_cnt, stall_cnt, host_rdata, latched addr/we/wdata to 0
  - core_hold and host_ack to 0
  - host_busy to 0
- Reset mid-transfer aborts the transfer. No ack is issued. Bits already written stay written.
- Bus mux (combinational):
  - If core_req = 1: io_addr/io_we/io_wdata = core signals.
  - Else if state = XFER: io_addr = base + bit_cnt (8-bit wrap), io_we = latched we, io_wdata = latched wdata[bit_cnt].
  - Else: io_addr = 0, io_we = 0, io_wdata = 0.
- core_rdata = io_rdata at all times.
- FSM states:
  - IDLE: on host_req = 1, latch addr/we/wdata, clear bit_cnt and stall_cnt, go to XFER.
  - XFER, core_req = 0: the bit access completes at the clock edge. On a read, capture io_rdata into rd_shadow[bit_cnt]. Increment bit_cnt and clear stall_cnt. When bit_cnt = WORD_BITS-1 completes, go to DONE.
  - XFER, core_req = 1: bit_cnt holds and stall_cnt increments (saturating).
  - DONE: host_ack = 1. On a read, host_rdata = rd_shadow, loaded at the DONE entry edge. Next state is IDLE unconditionally.
- host_req is ignored in XFER and DONE. A request needs at least one IDLE cycle between transfers.
- Latency with no core traffic: request accepted at edge E0; bit i completes at edge E(i+1); host_ack is high in the cycle after edge E(WORD_BITS). For WORD_BITS = 8 that is 9 cycles from acceptance to ack.
- core_hold:
  - Sets at the edge where stall_cnt reaches STARVE_LIMIT while in XFER (STARVE_LIMIT > 0).
  - Clears at the DONE entry edge or on reset.
  - If the core keeps core_req = 1 anyway, the core still wins. No protocol error is flagged.
- A host write does not change host_rdata.
- Address wrap: base 0xFC with WORD_BITS = 8 accesses 0xFC..0xFF, then 0x00..0x03.
- Addresses the I/O block treats as read-only or unmapped are still sequenced normally.

Test Plan:
- Reset: hold rst_n low mid-XFER of a write, release → host_busy = 0, host_ack never pulses, core_hold = 0, host_rdata = 0x00, bits already committed unchanged.
- Host write 0xA5 to base 0x80, no core traffic → io_we pulses at 0x80..0x87 with data 1,0,1,0,0,1,0,1; host_ack high exactly 9 cycles after acceptance.
- Host read base 0x80 after that write → host_rdata = 0xA5 during the ack cycle and held afterwards; io_we = 0 throughout.
- Host write in progress, core_req = 1 for 3 cycles mid-transfer → bus shows core address in those cycles, bit_cnt frozen, ack delayed by exactly 3 cycles, final data correct.
- STARVE_LIMIT = 4, core_req held high after 2 host bits → core_hold rises on the 4th blocked edge; drop core_req → remaining 6 bits complete, core_hold clears at DONE entry.
- Read base 0xFC with known pattern at 0xFC..0x03 → io_addr sequence wraps 0xFF→0x00 and host_rdata matches; host_req pulsed during XFER is ignored (exactly one ack).

Source files
------------

// File: rtl/ttlc_io_arb_if.sv
// Host-side word port of the TTLC I/O bus arbiter.
// The host drives requests through the master modport; the arbiter implements the slave side.
interface ttlc_io_arb_if #(
   parameter int unsigned WORD_BITS = 8
);
   logic                 host_req;
   logic                 host_we;
   logic [7:0]           host_addr;
   logic [WORD_BITS-1:0] host_wdata;
   logic                 host_ack;
   logic [WORD_BITS-1:0] host_rdata;
   logic                 host_busy;

   modport master (
      output host_req,
      output host_we,
      output host_addr,
      output host_wdata,
      input  host_ack,
      input  host_rdata,
      input  host_busy
   );

   modport slave (
      input  host_req,
      input  host_we,
      input  host_addr,
      input  host_wdata,
      output host_ack,
      output host_rdata,
      output host_busy
   );
endinterface

// File: rtl/ttlc_io_arb.sv
// Arbitrates the bit-addressed TTLC I/O bus between the MC14500 core (absolute priority)
// and a host word port that is serialised into single-bit accesses in core-idle cycles.
module ttlc_io_arb #(
   parameter int unsigned WORD_BITS    = 8,
   parameter int unsigned STARVE_LIMIT = 16
) (
   input  logic               clk,
   input  logic               rst_n,

   input  logic               core_req,
   input  logic [7:0]         core_addr,
   input  logic               core_we,
   input  logic               core_wdata,
   output logic               core_rdata,
   output logic               core_hold,

   ttlc_io_arb_if.slave       host,

   output logic [7:0]         io_addr,
   output logic               io_we,
   output logic               io_wdata,
   input  logic               io_rdata
);

   localparam int unsigned CntW   = (WORD_BITS > 1) ? $clog2(WORD_BITS) : 1;
   localparam int unsigned StallW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

   localparam logic [CntW-1:0]   LastBit  = CntW'(WORD_BITS - 1);
   localparam logic [StallW-1:0] StallMax = '1;
   localparam logic [StallW-1:0] StallLim = StallW'(STARVE_LIMIT);

   typedef enum logic [1:0] {
      StIdle,
      StXfer,
      StDone
   } state_e;

   state_e               state_q, state_d;
   logic [CntW-1:0]      bit_cnt_q, bit_cnt_d;
   logic [StallW-1:0]    stall_cnt_q, stall_cnt_d;
   logic [7:0]           addr_q, addr_d;
   logic                 we_q, we_d;
   logic [WORD_BITS-1:0] wdata_q, wdata_d;
   logic [WORD_BITS-1:0] rd_shadow_q, rd_shadow_d;
   logic [WORD_BITS-1:0] rdata_q, rdata_d;
   logic                 hold_q, hold_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         bit_cnt_q   <= '0;
         stall_cnt_q <= '0;
         addr_q      <= '0;
         we_q        <= 1'b0;
         wdata_q     <= '0;
         rd_shadow_q <= '0;
         rdata_q     <= '0;
         hold_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         stall_cnt_q <= stall_cnt_d;
         addr_q      <= addr_d;
         we_q        <= we_d;
         wdata_q     <= wdata_d;
         rd_shadow_q <= rd_shadow_d;
         rdata_q     <= rdata_d;
         hold_q      <= hold_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      stall_cnt_d = stall_cnt_q;
      addr_d      = addr_q;
      we_d        = we_q;
      wdata_d     = wdata_q;
      rd_shadow_d = rd_shadow_q;
      rdata_d     = rdata_q;
      hold_d      = hold_q;

      unique case (state_q)
         StIdle: begin
            if (host.host_req) begin
               addr_d      = host.host_addr;
               we_d        = host.host_we;
               wdata_d     = host.host_wdata;
               bit_cnt_d   = '0;
               stall_cnt_d = '0;
               state_d     = StXfer;
            end
         end
         StXfer: begin
            if (core_req) begin
               if (stall_cnt_q != StallMax) begin
                  stall_cnt_d = stall_cnt_q + StallW'(1);
               end
               // Sticky until the word completes, even if the core backs off earlier.
               if ((STARVE_LIMIT != 0) && (stall_cnt_d == StallLim)) begin
                  hold_d = 1'b1;
               end
            end else begin
               stall_cnt_d = '0;
               if (!we_q) begin
                  rd_shadow_d[bit_cnt_q] = io_rdata;
               end
               if (bit_cnt_q == LastBit) begin
                  state_d = StDone;
                  hold_d  = 1'b0;
                  // Last bit lands in the shadow on this same edge, so load from _d.
                  if (!we_q) begin
                     rdata_d = rd_shadow_d;
                  end
               end else begin
                  bit_cnt_d = bit_cnt_q + CntW'(1);
               end
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_comb begin
      io_addr  = 8'h00;
      io_we    = 1'b0;
      io_wdata = 1'b0;
      if (core_req) begin
         io_addr  = core_addr;
         io_we    = core_we;
         io_wdata = core_wdata;
      end else if (state_q == StXfer) begin
         io_addr  = addr_q + 8'(bit_cnt_q);
         io_we    = we_q;
         io_wdata = wdata_q[bit_cnt_q];
      end
   end

   assign core_rdata      = io_rdata;
   assign core_hold       = hold_q;
   assign host.host_ack   = (state_q == StDone);
   assign host.host_busy  = (state_q != StIdle);
   assign host.host_rdata = rdata_q;

endmodule
